// File: rtl/mips_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mips_pkg : shared access-size and arbiter-state types | rev 1.0
// ---------------------------------------------------------------------------
package mips_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  // The unused size code is checked like a word so it can never reach the bus unaligned
  function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] off);
    case (size)
      BYTE:    is_misaligned = 1'b0;
      HALF:    is_misaligned = off[0];
      default: is_misaligned = (off != 2'b00);
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mips_mem_align.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mips_mem_align : byte-lane steering for stores and load extraction | rev 1.0
// ---------------------------------------------------------------------------
module mips_mem_align
  import mips_pkg::*;
(
  input  mem_size_t   size,
  input  logic        sign_ext,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  byteenable,
  output logic [31:0] wdata_lanes,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  always_comb begin
    shifted     = rdata >> {offset, 3'b000};
    byteenable  = 4'b1111;
    wdata_lanes = wdata;
    load_data   = shifted;
    case (size)
      BYTE: begin
        byteenable  = 4'b0001 << offset;
        wdata_lanes = {4{wdata[7:0]}};
        load_data   = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
      end
      HALF: begin
        byteenable  = offset[1] ? 4'b1100 : 4'b0011;
        wdata_lanes = {2{wdata[15:0]}};
        load_data   = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
      end
      default: begin
        byteenable  = 4'b1111;
        wdata_lanes = wdata;
        load_data   = shifted;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mips_mem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mips_mem_arbiter : fetch/data port arbiter onto one Avalon-MM master | rev 1.0
// ---------------------------------------------------------------------------
module mips_mem_arbiter
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic        d_signed,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic        d_err,
  output logic [31:0] d_rdata,
  output logic        busy,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata,
  input  logic        waitrequest
);

  arb_state_t  state_q, state_d;
  logic        own_data_q, own_data_d;
  logic        we_q, we_d;
  mem_size_t   size_q, size_d;
  logic        signed_q, signed_d;
  logic [1:0]  off_q, off_d;

  logic        i_ack_q, i_ack_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic        d_ack_q, d_ack_d;
  logic        d_err_q, d_err_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        busy_q, busy_d;
  logic [31:0] address_q, address_d;
  logic        read_q, read_d;
  logic        write_q, write_d;
  logic [31:0] writedata_q, writedata_d;
  logic [3:0]  byteenable_q, byteenable_d;

  // In IDLE the aligner sees the live request; afterwards it sees the latched one
  mem_size_t   al_size;
  logic        al_signed;
  logic [1:0]  al_off;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_load;

  assign al_size   = (state_q == IDLE) ? mem_size_t'(d_size) : size_q;
  assign al_signed = (state_q == IDLE) ? d_signed : signed_q;
  assign al_off    = (state_q == IDLE) ? d_addr[1:0] : off_q;

  mips_mem_align u_align (
    .size        (al_size),
    .sign_ext    (al_signed),
    .offset      (al_off),
    .wdata       (d_wdata),
    .rdata       (readdata),
    .byteenable  (al_be),
    .wdata_lanes (al_wdata),
    .load_data   (al_load)
  );

  always_comb begin
    state_d      = state_q;
    own_data_d   = own_data_q;
    we_d         = we_q;
    size_d       = size_q;
    signed_d     = signed_q;
    off_d        = off_q;
    i_ack_d      = 1'b0;
    i_rdata_d    = i_rdata_q;
    d_ack_d      = 1'b0;
    d_err_d      = 1'b0;
    d_rdata_d    = d_rdata_q;
    address_d    = address_q;
    read_d       = read_q;
    write_d      = write_q;
    writedata_d  = writedata_q;
    byteenable_d = byteenable_q;

    case (state_q)
      IDLE: begin
        if (d_req) begin
          own_data_d = 1'b1;
          we_d       = d_we;
          size_d     = mem_size_t'(d_size);
          signed_d   = d_signed;
          off_d      = d_addr[1:0];
          if (is_misaligned(mem_size_t'(d_size), d_addr[1:0])) begin
            state_d   = RESP;
            d_ack_d   = 1'b1;
            d_err_d   = 1'b1;
            d_rdata_d = 32'h0;
          end else begin
            state_d      = BUS;
            address_d    = {d_addr[31:2], 2'b00};
            read_d       = ~d_we;
            write_d      = d_we;
            writedata_d  = al_wdata;
            byteenable_d = al_be;
          end
        end else if (i_req) begin
          own_data_d   = 1'b0;
          we_d         = 1'b0;
          size_d       = WORD;
          signed_d     = 1'b0;
          off_d        = i_addr[1:0];
          state_d      = BUS;
          address_d    = {i_addr[31:2], 2'b00};
          read_d       = 1'b1;
          write_d      = 1'b0;
          writedata_d  = 32'h0;
          byteenable_d = 4'b1111;
        end
      end
      BUS: begin
        if (!waitrequest) begin
          state_d = RESP;
          read_d  = 1'b0;
          write_d = 1'b0;
          if (own_data_q) begin
            d_ack_d   = 1'b1;
            d_rdata_d = we_q ? 32'h0 : al_load;
          end else begin
            i_ack_d   = 1'b1;
            i_rdata_d = readdata;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      own_data_q   <= 1'b0;
      we_q         <= 1'b0;
      size_q       <= BYTE;
      signed_q     <= 1'b0;
      off_q        <= 2'b00;
      i_ack_q      <= 1'b0;
      i_rdata_q    <= 32'h0;
      d_ack_q      <= 1'b0;
      d_err_q      <= 1'b0;
      d_rdata_q    <= 32'h0;
      busy_q       <= 1'b0;
      address_q    <= 32'h0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      writedata_q  <= 32'h0;
      byteenable_q <= 4'b0000;
    end else begin
      state_q      <= state_d;
      own_data_q   <= own_data_d;
      we_q         <= we_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
      off_q        <= off_d;
      i_ack_q      <= i_ack_d;
      i_rdata_q    <= i_rdata_d;
      d_ack_q      <= d_ack_d;
      d_err_q      <= d_err_d;
      d_rdata_q    <= d_rdata_d;
      busy_q       <= busy_d;
      address_q    <= address_d;
      read_q       <= read_d;
      write_q      <= write_d;
      writedata_q  <= writedata_d;
      byteenable_q <= byteenable_d;
    end
  end

  assign i_ack      = i_ack_q;
  assign i_rdata    = i_rdata_q;
  assign d_ack      = d_ack_q;
  assign d_err      = d_err_q;
  assign d_rdata    = d_rdata_q;
  assign busy       = busy_q;
  assign address    = address_q;
  assign read       = read_q;
  assign write      = write_q;
  assign writedata  = writedata_q;
  assign byteenable = byteenable_q;

endmodule
`default_nettype wire
